// File: rtl/fifo_ref_checker_pkg.sv
// Shared definitions for the FIFO reference checker: mismatch-mask bit positions
// and the mask type reported through err_first_mask.
package fifo_ref_checker_pkg;

  localparam int unsigned CHK_DOUT   = 0;
  localparam int unsigned CHK_WRACK  = 1;
  localparam int unsigned CHK_OVF    = 2;
  localparam int unsigned CHK_UDF    = 3;
  localparam int unsigned CHK_FULL   = 4;
  localparam int unsigned CHK_EMPTY  = 5;
  localparam int unsigned CHK_AFULL  = 6;
  localparam int unsigned CHK_AEMPTY = 7;

  typedef logic [7:0] chk_mask_t;

endpackage

// File: rtl/fifo_ref_checker_if.sv
// Pin bundle of the snooped FIFO: the FIFO (or its stand-in) drives it as master,
// the checker observes it as slave.
interface fifo_ref_checker_if #(
  parameter int unsigned FIFO_WIDTH = 16
) ();

  logic                  wr_en;
  logic                  rd_en;
  logic [FIFO_WIDTH-1:0] data_in;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;

  modport master (
    output wr_en, rd_en, data_in, data_out, wr_ack, overflow, underflow,
           full, empty, almostfull, almostempty
  );

  modport slave (
    input wr_en, rd_en, data_in, data_out, wr_ack, overflow, underflow,
          full, empty, almostfull, almostempty
  );

endinterface

// File: rtl/fifo_ref_mem.sv
// Ring-buffer FIFO model with occupancy counter; push/pop are the accepted
// operations, so a write on a full buffer or a read on an empty one is dropped.
module fifo_ref_mem #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = $clog2(DEPTH + 1),
  parameter int unsigned PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] data_in,
  output logic             push,
  output logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    cnt
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Full blocks the write half of wr&rd, empty blocks the read half.
  assign push = wr_en && (cnt != CW'(DEPTH));
  assign pop  = rd_en && (cnt != '0);
  assign head = mem[rd_ptr];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/fifo_ref_checker.sv
// In-line FIFO checker: models the snooped FIFO, compares its outputs every cycle
// and keeps saturating pass/fail counters plus a record of the first failure.
module fifo_ref_checker
  import fifo_ref_checker_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int unsigned AE_LEVEL   = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 chk_en,
  fifo_ref_checker_if.slave    pins,
  output logic [CNT_W-1:0]     correct_count,
  output logic [CNT_W-1:0]     error_count,
  output logic                 err_seen,
  output chk_mask_t            err_first_mask,
  output logic [CNT_W-1:0]     err_first_cycle
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic                  push;
  logic                  pop;
  logic [FIFO_WIDTH-1:0] head;
  logic [CW-1:0]         cnt;

  logic [FIFO_WIDTH-1:0] exp_dout;
  logic                  exp_dout_vld;
  logic                  exp_wr_ack;
  logic                  exp_overflow;
  logic                  exp_underflow;
  logic [CNT_W-1:0]      cycle;
  chk_mask_t             mask;

  fifo_ref_mem #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (pins.wr_en),
    .rd_en   (pins.rd_en),
    .data_in (pins.data_in),
    .push    (push),
    .pop     (pop),
    .head    (head),
    .cnt     (cnt)
  );

  // Flags are judged against the occupancy before this edge, registered
  // fields against the expectations captured on the previous edge.
  always_comb begin
    mask             = '0;
    mask[CHK_DOUT]   = exp_dout_vld && (pins.data_out != exp_dout);
    mask[CHK_WRACK]  = pins.wr_ack      != exp_wr_ack;
    mask[CHK_OVF]    = pins.overflow    != exp_overflow;
    mask[CHK_UDF]    = pins.underflow   != exp_underflow;
    mask[CHK_FULL]   = pins.full        != (cnt == CW'(FIFO_DEPTH));
    mask[CHK_EMPTY]  = pins.empty       != (cnt == '0);
    mask[CHK_AFULL]  = pins.almostfull  != (cnt == CW'(AF_LEVEL));
    mask[CHK_AEMPTY] = pins.almostempty != (cnt == CW'(AE_LEVEL));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_dout        <= '0;
      exp_dout_vld    <= 1'b0;
      exp_wr_ack      <= 1'b0;
      exp_overflow    <= 1'b0;
      exp_underflow   <= 1'b0;
      cycle           <= '0;
      correct_count   <= '0;
      error_count     <= '0;
      err_seen        <= 1'b0;
      err_first_mask  <= '0;
      err_first_cycle <= '0;
    end else begin
      exp_wr_ack    <= push;
      exp_overflow  <= pins.wr_en && (cnt == CW'(FIFO_DEPTH));
      exp_underflow <= pins.rd_en && (cnt == '0);
      if (pop) begin
        exp_dout     <= head;
        exp_dout_vld <= 1'b1;
      end
      if (cycle != '1) cycle <= cycle + CNT_W'(1);
      if (chk_en) begin
        if (mask == '0) begin
          if (correct_count != '1) correct_count <= correct_count + CNT_W'(1);
        end else begin
          if (error_count != '1) error_count <= error_count + CNT_W'(1);
          if (!err_seen) begin
            err_seen        <= 1'b1;
            err_first_mask  <= mask;
            err_first_cycle <= cycle;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_ref_checker.sv
// Drives two checkers (depth 8 / 16-bit counters, depth 5 / 4-bit counters) from a
// queue-based FIFO stand-in with deliberate pin corruptions; a scoreboard checks counters.
module tb_fifo_ref_checker;

  typedef struct packed {
    logic [15:0] corr;
    logic [15:0] err;
    logic        seen;
    logic [7:0]  mask;
    logic [15:0] fcyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic chk_en = 1'b0;

  logic [15:0] c8_corr, c8_err, c8_fcyc;
  logic        c8_seen;
  logic [7:0]  c8_mask;
  logic [3:0]  c5_corr, c5_err, c5_fcyc;
  logic        c5_seen;
  logic [7:0]  c5_mask;

  fifo_ref_checker_if #(.FIFO_WIDTH(16)) p8 ();
  fifo_ref_checker_if #(.FIFO_WIDTH(16)) p5 ();

  fifo_ref_checker #(.FIFO_WIDTH(16)) u8 (
    .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .pins(p8.slave),
    .correct_count(c8_corr), .error_count(c8_err), .err_seen(c8_seen),
    .err_first_mask(c8_mask), .err_first_cycle(c8_fcyc)
  );

  fifo_ref_checker #(
    .FIFO_WIDTH(16), .FIFO_DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(1), .CNT_W(4)
  ) u5 (
    .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .pins(p5.slave),
    .correct_count(c5_corr), .error_count(c5_err), .err_seen(c5_seen),
    .err_first_mask(c5_mask), .err_first_cycle(c5_fcyc)
  );

  always #5 clk = ~clk;

  // Stand-in FIFO state, per instance
  int          depth [2] = '{8, 5};
  int          afl   [2] = '{7, 3};
  int          ael   [2] = '{1, 1};
  int          cmax  [2] = '{65535, 15};
  logic [15:0] mq    [2][$];
  logic [15:0] rdout [2];
  logic        rack [2], rov [2], rud [2], dvld [2];

  // Expected checker state, per instance
  int          ecorr [2], eerr [2], ecyc [2], efcyc [2];
  logic        eseen [2];
  logic [7:0]  emask [2];
  exp_t        sb [2][$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int k, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d @%0t: got 0x%0h expected 0x%0h", name, k, $time, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb[0].size() > 0) begin
        e = sb[0].pop_front();
        chk("correct_count", 0, c8_corr, e.corr);
        chk("error_count", 0, c8_err, e.err);
        chk("err_seen", 0, {15'b0, c8_seen}, {15'b0, e.seen});
        chk("err_first_mask", 0, {8'b0, c8_mask}, {8'b0, e.mask});
        chk("err_first_cycle", 0, c8_fcyc, e.fcyc);
      end
      if (sb[1].size() > 0) begin
        e = sb[1].pop_front();
        chk("correct_count", 1, {12'b0, c5_corr}, e.corr);
        chk("error_count", 1, {12'b0, c5_err}, e.err);
        chk("err_seen", 1, {15'b0, c5_seen}, {15'b0, e.seen});
        chk("err_first_mask", 1, {8'b0, c5_mask}, {8'b0, e.mask});
        chk("err_first_cycle", 1, {12'b0, c5_fcyc}, e.fcyc);
      end
    end
  end

  function automatic exp_t snap(input int k);
    exp_t e;
    e.corr = 16'(ecorr[k]);
    e.err  = 16'(eerr[k]);
    e.seen = eseen[k];
    e.mask = emask[k];
    e.fcyc = 16'(efcyc[k]);
    return e;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    p8.wr_en = 1'b0; p8.rd_en = 1'b0;
    p5.wr_en = 1'b0; p5.rd_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      rack[k] = 1'b0; rov[k] = 1'b0; rud[k] = 1'b0; dvld[k] = 1'b0;
      ecorr[k] = 0; eerr[k] = 0; ecyc[k] = 0; efcyc[k] = 0;
      eseen[k] = 1'b0; emask[k] = 8'h00;
      sb[k].push_back(snap(k));
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: present pins (with faults f0/f1 applied), predict counters, advance the model.
  task automatic step(input logic wr, input logic rd, input logic [15:0] din,
                      input logic en, input logic [7:0] f0, input logic [7:0] f1);
    logic [7:0]  f, m, fl;
    logic [15:0] dout;
    int          s;
    chk_en = en;
    for (int k = 0; k < 2; k++) begin
      f  = (k == 0) ? f0 : f1;
      s  = mq[k].size();
      fl = {s == ael[k], s == afl[k], s == 0, s == depth[k], rud[k], rov[k], rack[k], 1'b0} ^ f;
      dout = f[0] ? 16'hDEAD : rdout[k];
      if (k == 0) begin
        p8.wr_en = wr; p8.rd_en = rd; p8.data_in = din; p8.data_out = dout;
        {p8.almostempty, p8.almostfull, p8.empty, p8.full,
         p8.underflow, p8.overflow, p8.wr_ack} = fl[7:1];
      end else begin
        p5.wr_en = wr; p5.rd_en = rd; p5.data_in = din; p5.data_out = dout;
        {p5.almostempty, p5.almostfull, p5.empty, p5.full,
         p5.underflow, p5.overflow, p5.wr_ack} = fl[7:1];
      end
      // Stored data never has bit 15 set, so a 0xDEAD corruption always differs.
      m = dvld[k] ? f : (f & 8'hFE);
      if (en) begin
        if (m == 8'h00) begin
          if (ecorr[k] < cmax[k]) ecorr[k]++;
        end else begin
          if (eerr[k] < cmax[k]) eerr[k]++;
          if (!eseen[k]) begin
            eseen[k] = 1'b1; emask[k] = m; efcyc[k] = ecyc[k];
          end
        end
      end
      if (ecyc[k] < cmax[k]) ecyc[k]++;
      sb[k].push_back(snap(k));
      rov[k]  = wr && (s == depth[k]);
      rud[k]  = rd && (s == 0);
      rack[k] = wr && (s < depth[k]);
      if (rd && s > 0) begin
        rdout[k] = mq[k].pop_front();
        dvld[k]  = 1'b1;
      end
      if (rack[k]) mq[k].push_back(din);
    end
    @(negedge clk);
  endtask

  initial begin
    int wp;
    rdout[0] = 16'h0; rdout[1] = 16'h0;
    p8.data_in = '0; p8.data_out = '0; p5.data_in = '0; p5.data_out = '0;
    do_reset();
    // Corruptions before any read: data_out must be masked, flags must not be
    step(1'b0, 1'b0, 16'h0, 1'b1, 8'h01, 8'h01);
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 16'(i), 1'b1, 8'h00, 8'h00);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h0, 1'b1, 8'h00, 8'h00);
    // Full then wr&rd, drain, empty then wr&rd
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'($urandom & 16'h7FFF), 1'b1, 8'h00, 8'h00);
    step(1'b1, 1'b1, 16'hAAAA & 16'h7FFF, 1'b1, 8'h00, 8'h00);
    step(1'b0, 1'b0, 16'h0, 1'b1, 8'h00, 8'h00);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h0, 1'b1, 8'h00, 8'h00);
    step(1'b1, 1'b1, 16'h1234, 1'b1, 8'h00, 8'h00);
    step(1'b0, 1'b0, 16'h0, 1'b1, 8'h00, 8'h00);
    // Data corruption during reads on the depth-8 instance only
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'(16'h100 + i), 1'b1, 8'h00, 8'h00);
    step(1'b0, 1'b1, 16'h0, 1'b1, 8'h00, 8'h00);
    step(1'b0, 1'b1, 16'h0, 1'b1, 8'h01, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'h0, 1'b1, 8'h00, 8'h00);
    // Each status/flag field corrupted once; the last one with checking disabled
    for (int b = 1; b < 8; b++) step(1'b0, 1'b0, 16'h0, 1'b1, 8'(1 << b), 8'(1 << b));
    step(1'b0, 1'b0, 16'h0, 1'b0, 8'h10, 8'h10);
    // Reset with 5 words stored, then one read
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'(16'h200 + i), 1'b1, 8'h00, 8'h00);
    do_reset();
    step(1'b0, 1'b1, 16'h0, 1'b1, 8'h00, 8'h00);
    step(1'b0, 1'b0, 16'h0, 1'b1, 8'h00, 8'h00);
    // Randomised traffic with alternating fill/drain bias
    for (int i = 0; i < 600; i++) begin
      logic [7:0] f0, f1;
      wp = ((i / 40) % 2 == 0) ? 75 : 25;
      f0 = ($urandom_range(0, 19) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      f1 = ($urandom_range(0, 19) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      if ($urandom_range(0, 199) == 0) do_reset();
      step($urandom_range(0, 99) < wp, $urandom_range(0, 99) >= wp - 10,
           16'($urandom & 16'h7FFF), $urandom_range(0, 9) != 0, f0, f1);
    end
    for (int i = 0; i < 10 && (sb[0].size() > 0 || sb[1].size() > 0); i++) @(negedge clk);
    if (sb[0].size() > 0 || sb[1].size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d/%0d entries left, expected 0", sb[0].size(), sb[1].size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
